rsa_const_unit: RTL and testbench



---
 rtl/rsa_pkg.sv | 17 +
 rtl/mod_dbl_step.sv | 22 ++
 rtl/rsa_const_unit.sv | 142 ++++++++++++++
 tb/tb_rsa_const_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA Montgomery pre-computation logic.
//   state_e      : control states of rsa_const_unit (idle / running / finishing)
//   const_shifts : number of modular doublings for a given operand width,
//                  sized for the WIDTH+2-bit Montgomery multipliers downstream.
package rsa_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

  function automatic int unsigned const_shifts(input int unsigned width);
    return 2 * (width + 2);
  endfunction

endpackage

// File: rtl/mod_dbl_step.sv
// One modular doubling step: r_o = (2*r_i >= m_i) ? 2*r_i - m_i : 2*r_i.
// Purely combinational.
//   r_i : current residue, r_i < m_i
//   m_i : modulus
//   r_o : next residue, r_o < m_i
module mod_dbl_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] r_o
);

  logic [WIDTH:0] t;
  logic           ge;

  assign t  = {r_i, 1'b0};
  assign ge = (t >= {1'b0, m_i});
  // Because r_i < m_i, t - m_i < m_i, so the low WIDTH bits of the difference are exact.
  assign r_o = ge ? (t[WIDTH-1:0] - m_i) : t[WIDTH-1:0];

endmodule

// File: rtl/rsa_const_unit.sv
// Montgomery constant generator: Const = 2^SHIFTS mod M, computed by SHIFTS
// modular doublings of r (starting from 1 reduced mod M), one per enabled cycle.
// Optional build macro: RSA_CONST_MODCHECK_EN rejects zero/even moduli (err=1,
// Const=0, done one cycle after acceptance). Without it err is tied low.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   ena   : clock enable, all state holds when low
//   start : computation request, sampled only while idle
//   M     : modulus, captured on the accepting edge
//   Const : result, held until the next done edge
//   busy  : high from the accepting edge until the done edge
//   done  : one-cycle pulse, Const valid in that cycle
//   err   : modulus rejected, updated with Const
module rsa_const_unit
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SHIFTS = const_shifts(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] Const,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CntW = $clog2(SHIFTS + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] const_q, const_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_r;

`ifdef RSA_CONST_MODCHECK_EN
  // rej_q remembers a rejected modulus until the done edge publishes it on err.
  logic             err_q, err_d;
  logic             rej_q, rej_d;
`endif

  mod_dbl_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r_i(r_q),
    .m_i(m_q),
    .r_o(step_r)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    const_d = const_q;
    done_d  = 1'b0;  // done never holds: exactly one pulse per result
`ifdef RSA_CONST_MODCHECK_EN
    err_d   = err_q;
    rej_d   = rej_q;
`endif
    if (ena) begin
      case (state_q)
        StIdle: begin
          if (start) begin
            m_d     = M;
            // Initial 1 reduced mod M: only M=1 changes it.
            r_d     = (M == WIDTH'(1)) ? '0 : WIDTH'(1);
            cnt_d   = '0;
            state_d = StRun;
`ifdef RSA_CONST_MODCHECK_EN
            err_d   = 1'b0;
            rej_d   = 1'b0;
            if ((M == '0) || !M[0]) begin
              r_d     = '0;
              rej_d   = 1'b1;
              state_d = StFin;
            end
`endif
          end
        end
        StRun: begin
          r_d   = step_r;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(SHIFTS - 1)) begin
            state_d = StFin;
          end
        end
        StFin: begin
          const_d = r_q;
          done_d  = 1'b1;
          state_d = StIdle;
`ifdef RSA_CONST_MODCHECK_EN
          err_d   = rej_q;
`endif
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      m_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      const_q <= '0;
      done_q  <= 1'b0;
`ifdef RSA_CONST_MODCHECK_EN
      err_q   <= 1'b0;
      rej_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      const_q <= const_d;
      done_q  <= done_d;
`ifdef RSA_CONST_MODCHECK_EN
      err_q   <= err_d;
      rej_q   <= rej_d;
`endif
    end
  end

  assign Const = const_q;
  assign busy  = (state_q != StIdle);
  assign done  = done_q;
`ifdef RSA_CONST_MODCHECK_EN
  assign err   = err_q;
`else
  assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_const_unit.sv
module tb_rsa_const_unit;

  localparam int unsigned Width  = 8;
  localparam int unsigned Shifts = 2 * (Width + 2);

  logic             clk = 1'b0;
  logic             rst;
  logic             ena;
  logic             start;
  logic [Width-1:0] M;
  logic [Width-1:0] Const;
  logic             busy;
  logic             done;
  logic             err;

  int n_vec = 0;
  int n_err = 0;

`ifdef RSA_CONST_MODCHECK_EN
  localparam bit ModCheck = 1'b1;
`else
  localparam bit ModCheck = 1'b0;
`endif

  rsa_const_unit #(
    .WIDTH(Width)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .start(start),
    .M    (M),
    .Const(Const),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: 2^Shifts mod m by plain integer arithmetic.
  function automatic longint ref_const(input int m);
    longint p;
    p = longint'(1) << Shifts;
    return p % m;
  endfunction

  function automatic bit rejected(input int m);
    return ModCheck && ((m == 0) || (m % 2 == 0));
  endfunction

  // Start one computation and follow it to its done pulse.
  // rand_ena toggles ena randomly while busy; poke holds start high while busy;
  // M is scrambled right after capture.
  task automatic run_one(input int m, input bit rand_ena, input bit poke);
    int cyc;
    int dones;
    bit seen;
    @(negedge clk);
    M     = Width'(m);
    start = 1'b1;
    ena   = 1'b1;
    @(negedge clk);  // acceptance edge has passed
    check_eq("busy_after_accept", busy, 1);
    start = poke;
    M     = Width'($urandom);
    cyc   = 0;
    dones = 0;
    seen  = 1'b0;
    while (!seen && cyc < 400) begin
      if (rand_ena) ena = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
      if (done) begin
        seen  = 1'b1;
        dones = 1;
        start = 1'b0;
        ena   = 1'b1;
      end
    end
    check_eq("done_seen", seen, 1);
    if (!rand_ena) check_eq("latency", cyc, rejected(m) ? 1 : Shifts + 1);
    check_eq("const", Const, rejected(m) ? 0 : ref_const(m));
    check_eq("err", err, rejected(m) ? 1 : 0);
    check_eq("busy_at_done", busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) check_eq("busy_after_done", busy, 0);
    end
    check_eq("done_count", dones, 1);
  endtask

  initial begin
    rst   = 1'b1;
    ena   = 1'b0;
    start = 1'b0;
    M     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_const", Const, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);

    // Directed moduli
    run_one(251, 1'b0, 1'b0);
    run_one(13, 1'b0, 1'b0);
    run_one(255, 1'b0, 1'b0);
    run_one(1, 1'b0, 1'b0);
    run_one(250, 1'b0, 1'b0);
    // Ena toggled and start poked while busy
    run_one(251, 1'b1, 1'b1);

    // Reset in the middle of RUN
    @(negedge clk);
    M     = 8'd251;
    start = 1'b1;
    ena   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_const", Const, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_err", err, 0);
    rst = 1'b0;
    run_one(13, 1'b0, 1'b0);

    // Random moduli and random enable/poke patterns
    for (int k = 0; k < 12; k++) begin
      run_one(int'($urandom_range(1, 255)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
